// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 turn controller and its helpers.
package game2048_pkg;

    localparam int          TILE_W    = 12;
    localparam int          SCORE_W   = 20;
    localparam int          WIN_VALUE = 2048;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef logic [TILE_W-1:0] tile_t;
    typedef tile_t [3:0][3:0]  board_t;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        MOVE,
        SPAWN,
        CHECK,
        OVER
    } state_t;

    // True when exactly one of the four direction bits is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/board_status.sv
// Combinational board summary: any empty cell, any winning tile, and any
// horizontally or vertically adjacent pair of equal nonzero tiles.
module board_status #(
    parameter int TILE_W    = game2048_pkg::TILE_W,
    parameter int WIN_VALUE = game2048_pkg::WIN_VALUE
) (
    input  logic [3:0][3:0][TILE_W-1:0] board,
    output logic                        has_empty,
    output logic                        has_win,
    output logic                        has_pair
);

    localparam logic [TILE_W-1:0] WIN_TILE = TILE_W'(WIN_VALUE);

    // Scan every cell and its right and lower neighbours.
    always_comb begin
        has_empty = 1'b0;
        has_win   = 1'b0;
        has_pair  = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board[r][c] == '0) begin
                    has_empty = 1'b1;
                end
                if (board[r][c] == WIN_TILE) begin
                    has_win = 1'b1;
                end
                // Pairs of zeros are not merges; they only matter when the board is full anyway.
                if (c < 3) begin
                    if ((board[r][c] != '0) && (board[r][c] == board[r][c+1])) begin
                        has_pair = 1'b1;
                    end
                end
                if (r < 3) begin
                    if ((board[r][c] != '0) && (board[r][c] == board[r+1][c])) begin
                        has_pair = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn controller for the 2048 game: owns the board and score registers,
// issues a move direction to the move/merge stage, spawns tiles from an
// LFSR and evaluates win/lose after each turn.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   INIT  | start of game; launches two spawns, then goes to IDLE
//   IDLE  | waiting for a one-hot button request (btn_ready high)
//   MOVE  | move_dir driven; capture moved board and score increment
//   SPAWN | probe one cell per cycle from an LFSR start index, fill first empty
//   CHECK | evaluate win / lose on the registered board
//   OVER  | game decided; only new_game (or load_en) leaves
module game_turn_ctrl #(
    parameter int          TILE_W    = game2048_pkg::TILE_W,
    parameter int          SCORE_W   = game2048_pkg::SCORE_W,
    parameter int          WIN_VALUE = game2048_pkg::WIN_VALUE,
    parameter logic [15:0] LFSR_SEED = game2048_pkg::LFSR_SEED
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        btn_valid,
    input  logic [3:0]                  btn_dir,
    output logic                        btn_ready,
    input  logic                        new_game,
    input  logic                        load_en,
    input  logic [3:0][3:0][TILE_W-1:0] load_board,
    output logic [3:0]                  move_dir,
    output logic [3:0][3:0][TILE_W-1:0] board_q,
    input  logic [3:0][3:0][TILE_W-1:0] board_moved,
    input  logic [SCORE_W-1:0]          score_update,
    output logic [SCORE_W-1:0]          score,
    output logic                        game_won,
    output logic                        game_lost
);

    import game2048_pkg::*;

    state_t                        state_q, state_d;
    logic [3:0][3:0][TILE_W-1:0]   board_d;
    logic [SCORE_W-1:0]            score_q, score_d;
    logic [3:0]                    move_dir_q, move_dir_d;
    logic                          won_q, won_d;
    logic                          lost_q, lost_d;
    logic [15:0]                   lfsr_q;
    logic [1:0]                    spawn_cnt_q, spawn_cnt_d;
    logic                          from_init_q, from_init_d;
    logic [3:0]                    idx_q, idx_d;
    logic [3:0]                    probe_q, probe_d;
    logic [TILE_W-1:0]             val_q, val_d;

    logic                          has_empty;
    logic                          has_win;
    logic                          has_pair;
    logic [SCORE_W:0]              score_sum;
    logic [TILE_W-1:0]             spawn_val;
    logic                          lfsr_fb;
    logic                          spawn_done;

    board_status #(
        .TILE_W    (TILE_W),
        .WIN_VALUE (WIN_VALUE)
    ) u_board_status (
        .board     (board_q),
        .has_empty (has_empty),
        .has_win   (has_win),
        .has_pair  (has_pair)
    );

    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign spawn_val = (lfsr_q[7:4] == 4'hF) ? TILE_W'(4) : TILE_W'(2);
    assign score_sum = {1'b0, score_q} + {1'b0, score_update};

    assign btn_ready = (state_q == IDLE);
    assign move_dir  = move_dir_q;
    assign score     = score_q;
    assign game_won  = won_q;
    assign game_lost = lost_q;

    // Free-running spawn randomness; keeps advancing across new_game.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            board_q     <= '0;
            score_q     <= '0;
            move_dir_q  <= '0;
            won_q       <= 1'b0;
            lost_q      <= 1'b0;
            spawn_cnt_q <= 2'd0;
            from_init_q <= 1'b0;
            idx_q       <= 4'd0;
            probe_q     <= 4'd0;
            val_q       <= '0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            score_q     <= score_d;
            move_dir_q  <= move_dir_d;
            won_q       <= won_d;
            lost_q      <= lost_d;
            spawn_cnt_q <= spawn_cnt_d;
            from_init_q <= from_init_d;
            idx_q       <= idx_d;
            probe_q     <= probe_d;
            val_q       <= val_d;
        end
    end

    // Next-state and datapath updates; new_game outranks load_en, which outranks the FSM.
    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        score_d     = score_q;
        move_dir_d  = move_dir_q;
        won_d       = won_q;
        lost_d      = lost_q;
        spawn_cnt_d = spawn_cnt_q;
        from_init_d = from_init_q;
        idx_d       = idx_q;
        probe_d     = probe_q;
        val_d       = val_q;
        spawn_done  = 1'b0;

        if (new_game) begin
            board_d     = '0;
            score_d     = '0;
            won_d       = 1'b0;
            lost_d      = 1'b0;
            spawn_cnt_d = 2'd0;
            from_init_d = 1'b0;
            move_dir_d  = '0;
            state_d     = INIT;
        end else if (load_en) begin
            board_d    = load_board;
            won_d      = 1'b0;
            lost_d     = 1'b0;
            move_dir_d = '0;
            state_d    = CHECK;
        end else begin
            unique case (state_q)
                INIT: begin
                    if (spawn_cnt_q == 2'd2) begin
                        state_d = IDLE;
                    end else begin
                        from_init_d = 1'b1;
                        idx_d       = lfsr_q[3:0];
                        val_d       = spawn_val;
                        probe_d     = 4'd0;
                        state_d     = SPAWN;
                    end
                end
                IDLE: begin
                    if (btn_valid && is_onehot4(btn_dir)) begin
                        move_dir_d = btn_dir;
                        state_d    = MOVE;
                    end
                end
                MOVE: begin
                    move_dir_d = '0;
                    if (board_moved == board_q) begin
                        state_d = IDLE;
                    end else begin
                        board_d     = board_moved;
                        score_d     = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                        from_init_d = 1'b0;
                        idx_d       = lfsr_q[3:0];
                        val_d       = spawn_val;
                        probe_d     = 4'd0;
                        state_d     = SPAWN;
                    end
                end
                SPAWN: begin
                    if (board_q[idx_q[3:2]][idx_q[1:0]] == '0) begin
                        board_d[idx_q[3:2]][idx_q[1:0]] = val_q;
                        spawn_done = 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        probe_d = probe_q + 4'd1;
                        // Full board: give up after the 16th probe, board unchanged.
                        if (probe_q == 4'd15) begin
                            spawn_done = 1'b1;
                        end
                    end
                    if (spawn_done) begin
                        if (from_init_q) begin
                            spawn_cnt_d = spawn_cnt_q + 2'd1;
                            state_d     = INIT;
                        end else begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (has_win) begin
                        won_d   = 1'b1;
                        state_d = OVER;
                    end else if (!has_empty && !has_pair) begin
                        lost_d  = 1'b1;
                        state_d = OVER;
                    end else begin
                        state_d = IDLE;
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed self-checking bench for game_turn_ctrl. The bench plays the part
// of the move/merge stage by presenting hand-computed moved boards.
module tb_game_turn_ctrl;

    logic                    clk;
    logic                    rst_n;
    logic                    btn_valid;
    logic [3:0]              btn_dir;
    logic                    btn_ready;
    logic                    new_game;
    logic                    load_en;
    logic [3:0][3:0][11:0]   load_board;
    logic [3:0]              move_dir;
    logic [3:0][3:0][11:0]   board_q;
    logic [3:0][3:0][11:0]   board_moved;
    logic [19:0]             score_update;
    logic [19:0]             score;
    logic                    game_won;
    logic                    game_lost;

    int checks   = 0;
    int failures = 0;
    logic [19:0]           exp_score;
    logic [3:0][3:0][11:0] snap;

    game_turn_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_valid    (btn_valid),
        .btn_dir      (btn_dir),
        .btn_ready    (btn_ready),
        .new_game     (new_game),
        .load_en      (load_en),
        .load_board   (load_board),
        .move_dir     (move_dir),
        .board_q      (board_q),
        .board_moved  (board_moved),
        .score_update (score_update),
        .score        (score),
        .game_won     (game_won),
        .game_lost    (game_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int count_nz(input logic [3:0][3:0][11:0] b);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] != 12'd0) n++;
        return n;
    endfunction

    // 1 when every nonzero cell outside (skip_r, skip_c) holds 2 or 4.
    function automatic logic only_24(input logic [3:0][3:0][11:0] b, input int skip_r, input int skip_c);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!(r == skip_r && c == skip_c) && b[r][c] != 12'd0 && b[r][c] != 12'd2 && b[r][c] != 12'd4)
                    return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!btn_ready && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic press(input logic [3:0] dir);
        btn_valid = 1'b1;
        btn_dir   = dir;
        step();
        btn_valid = 1'b0;
        btn_dir   = 4'b0000;
    endtask

    task automatic do_load(input logic [3:0][3:0][11:0] b);
        load_board = b;
        load_en    = 1'b1;
        step();
        load_en    = 1'b0;
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        #12;
        checks++; if (board_q !== '0) begin failures++; $display("FAIL reset_board got=%h exp=0", board_q); end
        checks++; if (score !== 20'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if ({move_dir, btn_ready, game_won, game_lost} !== 7'd0) begin failures++;
            $display("FAIL reset_outs got dir=%b rdy=%b won=%b lost=%b exp all 0", move_dir, btn_ready, game_won, game_lost); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        checks++; if (n >= 200) begin failures++; $display("FAIL reset_ready_timeout got=%0d cycles exp<200", n); end
        checks++; if (count_nz(board_q) !== 2) begin failures++; $display("FAIL reset_two_tiles got=%0d exp=2", count_nz(board_q)); end
        checks++; if (only_24(board_q, -1, -1) !== 1'b1) begin failures++; $display("FAIL reset_tile_vals got=%h exp tiles in {2,4}", board_q); end
        checks++; if ({score, game_won, game_lost} !== 22'd0) begin failures++;
            $display("FAIL reset_after_init got score=%0d won=%b lost=%b exp 0", score, game_won, game_lost); end
        exp_score = 20'd0;
    endtask

    task automatic test_bad_request();
        snap = board_q;
        btn_valid = 1'b1; btn_dir = 4'b0011; step();
        checks++; if ({btn_ready, move_dir} !== 5'b1_0000) begin failures++;
            $display("FAIL bad_dir_0011 got rdy=%b dir=%b exp rdy=1 dir=0000", btn_ready, move_dir); end
        btn_dir = 4'b0000; step();
        checks++; if ({btn_ready, move_dir} !== 5'b1_0000) begin failures++;
            $display("FAIL bad_dir_0000 got rdy=%b dir=%b exp rdy=1 dir=0000", btn_ready, move_dir); end
        btn_valid = 1'b0; btn_dir = 4'b0100; step();
        checks++; if ({btn_ready, move_dir} !== 5'b1_0000 || board_q !== snap) begin failures++;
            $display("FAIL no_valid got rdy=%b dir=%b exp rdy=1 dir=0000 board unchanged", btn_ready, move_dir); end
        btn_dir = 4'b0000;
    endtask

    task automatic test_move_merge();
        logic [3:0][3:0][11:0] b;
        int n;
        b = '0; b[0][0] = 12'd2; b[0][1] = 12'd2;
        do_load(b);
        wait_ready(n);
        board_moved = '0; board_moved[0][0] = 12'd4; score_update = 20'd4;
        press(4'b0100);
        checks++; if ({btn_ready, move_dir} !== 5'b0_0100) begin failures++;
            $display("FAIL merge_move_dir got rdy=%b dir=%b exp rdy=0 dir=0100", btn_ready, move_dir); end
        wait_ready(n);
        exp_score = exp_score + 20'd4;
        checks++; if (n < 3 || n > 18) begin failures++; $display("FAIL merge_latency got=%0d exp 3..18", n); end
        checks++; if (board_q[0][0] !== 12'd4) begin failures++; $display("FAIL merge_cell00 got=%0d exp=4", board_q[0][0]); end
        checks++; if (count_nz(board_q) !== 2 || only_24(board_q, 0, 0) !== 1'b1) begin failures++;
            $display("FAIL merge_spawn got=%h exp one extra 2/4 tile", board_q); end
        checks++; if (score !== exp_score) begin failures++; $display("FAIL merge_score got=%0d exp=%0d", score, exp_score); end
    endtask

    task automatic test_no_change();
        logic [3:0][3:0][11:0] b;
        int n;
        b = '0; b[0][0] = 12'd2; b[1][0] = 12'd4; b[2][0] = 12'd8; b[3][0] = 12'd16;
        do_load(b);
        wait_ready(n);
        board_moved = b; score_update = 20'd8;
        press(4'b0001);
        checks++; if (move_dir !== 4'b0001) begin failures++; $display("FAIL nochg_move_dir got=%b exp=0001", move_dir); end
        step();
        checks++; if ({btn_ready, move_dir} !== 5'b1_0000) begin failures++;
            $display("FAIL nochg_back_idle got rdy=%b dir=%b exp rdy=1 dir=0000", btn_ready, move_dir); end
        checks++; if (board_q !== b) begin failures++; $display("FAIL nochg_board got=%h exp=%h", board_q, b); end
        checks++; if (score !== exp_score) begin failures++; $display("FAIL nochg_score got=%0d exp=%0d", score, exp_score); end
    endtask

    task automatic test_full_spawn();
        logic [3:0][3:0][11:0] b;
        int n;
        for (int i = 0; i < 16; i++) begin b[i/4][i%4] = 12'd2; board_moved[i/4][i%4] = 12'd8; end
        do_load(b);
        wait_ready(n);
        score_update = 20'd0;
        press(4'b1000);
        wait_ready(n);
        // MOVE (1) + 16 probes + CHECK (1)
        checks++; if (n !== 18) begin failures++; $display("FAIL full_latency got=%0d exp=18", n); end
        checks++; if (board_q !== board_moved) begin failures++; $display("FAIL full_board got=%h exp all 8", board_q); end
        checks++; if ({game_won, game_lost} !== 2'b00) begin failures++; $display("FAIL full_flags got=%b%b exp=00", game_won, game_lost); end
    endtask

    task automatic test_score_sat();
        logic [3:0][3:0][11:0] b;
        int n;
        b = '0; b[0][0] = 12'd2;
        board_moved = '0; board_moved[0][3] = 12'd2;
        score_update = 20'hFFFFF;
        do_load(b); wait_ready(n);
        press(4'b1000); wait_ready(n);
        checks++; if (score !== 20'hFFFFF) begin failures++; $display("FAIL sat_first got=%h exp=fffff", score); end
        score_update = 20'd5;
        do_load(b); wait_ready(n);
        press(4'b1000); wait_ready(n);
        checks++; if (score !== 20'hFFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=fffff", score); end
        exp_score = 20'hFFFFF;
    endtask

    task automatic test_win();
        logic [3:0][3:0][11:0] b;
        int n;
        b = '0; b[0][0] = 12'd1024; b[0][1] = 12'd1024;
        do_load(b); wait_ready(n);
        board_moved = '0; board_moved[0][0] = 12'd2048; score_update = 20'd2048;
        press(4'b0100);
        n = 0;
        while (!game_won && n < 50) begin step(); n++; end
        checks++; if ({game_won, game_lost, btn_ready} !== 3'b100) begin failures++;
            $display("FAIL win_flags got won=%b lost=%b rdy=%b exp 1 0 0", game_won, game_lost, btn_ready); end
        checks++; if (board_q[0][0] !== 12'd2048 || count_nz(board_q) !== 2) begin failures++;
            $display("FAIL win_board got=%h exp 2048 plus one spawn", board_q); end
        snap = board_q;
        board_moved = '0; board_moved[0][3] = 12'd2048; score_update = 20'd7;
        press(4'b1000); step(); step();
        checks++; if (board_q !== snap || move_dir !== 4'b0000 || btn_ready !== 1'b0 || score !== exp_score) begin failures++;
            $display("FAIL win_ignore got dir=%b rdy=%b score=%0d exp dir=0000 rdy=0 score=%0d board held", move_dir, btn_ready, score, exp_score); end
        do_new_game();
        exp_score = 20'd0;
        checks++; if ({game_won, game_lost} !== 2'b00 || score !== 20'd0 || board_q !== '0) begin failures++;
            $display("FAIL newgame_clear got won=%b lost=%b score=%0d exp 0 0 0 board 0", game_won, game_lost, score); end
        wait_ready(n);
        checks++; if (n >= 200 || count_nz(board_q) !== 2 || only_24(board_q, -1, -1) !== 1'b1) begin failures++;
            $display("FAIL newgame_tiles got n=%0d tiles=%0d exp two 2/4 tiles", n, count_nz(board_q)); end
    endtask

    task automatic test_lose();
        logic [3:0][3:0][11:0] b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
        do_load(b);
        checks++; if (game_lost !== 1'b0) begin failures++; $display("FAIL lose_early got=%b exp=0", game_lost); end
        step();
        checks++; if ({game_lost, game_won, btn_ready} !== 3'b100) begin failures++;
            $display("FAIL lose_flag got lost=%b won=%b rdy=%b exp 1 0 0", game_lost, game_won, btn_ready); end
        board_moved = '0; score_update = 20'd2;
        press(4'b0011); press(4'b0100); step();
        checks++; if (board_q !== b || move_dir !== 4'b0000 || game_lost !== 1'b1 || score !== exp_score) begin failures++;
            $display("FAIL lose_ignore got dir=%b lost=%b score=%0d exp 0000 1 %0d board held", move_dir, game_lost, score, exp_score); end
    endtask

    task automatic test_async_reset();
        logic [3:0][3:0][11:0] b;
        int n;
        do_new_game(); wait_ready(n);
        b = '0; b[0][0] = 12'd2; b[0][1] = 12'd2;
        do_load(b); wait_ready(n);
        board_moved = '0; board_moved[0][0] = 12'd4; score_update = 20'd4;
        press(4'b0100);
        step();
        checks++; if (board_q[0][0] !== 12'd4 || score !== 20'd4 || btn_ready !== 1'b0) begin failures++;
            $display("FAIL areset_pre got cell=%0d score=%0d rdy=%b exp 4 4 0", board_q[0][0], score, btn_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (board_q !== '0 || score !== 20'd0 || {move_dir, btn_ready, game_won, game_lost} !== 7'd0) begin failures++;
            $display("FAIL areset_outs got score=%0d dir=%b rdy=%b won=%b lost=%b exp all 0", score, move_dir, btn_ready, game_won, game_lost); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        checks++; if (n >= 200 || count_nz(board_q) !== 2 || only_24(board_q, -1, -1) !== 1'b1) begin failures++;
            $display("FAIL areset_respawn got n=%0d tiles=%0d exp two 2/4 tiles", n, count_nz(board_q)); end
    endtask

    initial begin
        rst_n        = 1'b0;
        btn_valid    = 1'b0;
        btn_dir      = 4'b0000;
        new_game     = 1'b0;
        load_en      = 1'b0;
        load_board   = '0;
        board_moved  = '0;
        score_update = 20'd0;
        exp_score    = 20'd0;
        snap         = '0;

        test_reset();
        test_bad_request();
        test_move_merge();
        test_no_change();
        test_full_spawn();
        test_score_sat();
        test_win();
        test_lose();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
